// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/onehot_dec2to4.sv
// Combinational 2-to-4 decoder with enable; all outputs low when disabled.
module onehot_dec2to4
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    input  logic               en,
    output logic [NUM_REQ-1:0] onehot
);

    // Set the single bit selected by idx, only while enabled.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time per owner.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    localparam int HC_W = $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);

    state_t              state, state_n;
    logic [IDX_W-1:0]    last_idx, last_idx_n;
    logic [IDX_W-1:0]    idx_n;
    logic [HC_W-1:0]     hold_cnt, hold_cnt_n;

    logic [IDX_W-1:0]    base;
    logic [2:0]          shamt;
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]  rot;
    logic [IDX_W-1:0]    first;
    logic [IDX_W-1:0]    win_idx;
    logic                any_req;
    logic                others_req;
    logic [NUM_REQ-1:0]  gnt_n;

    // Priority search: rotate so base+1 lands at bit 0, find the first set bit, rotate back.
    always_comb begin
        base  = (state == GRANT) ? gnt_idx : last_idx;
        shamt = {1'b0, base} + 3'd1;
        dbl   = {req, req} >> shamt;
        rot   = dbl[NUM_REQ-1:0];
        first = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                first = IDX_W'(k);
            end
        end
        win_idx    = first + base + 2'd1;
        any_req    = |req;
        others_req = |(req & ~(NUM_REQ'(1) << gnt_idx));
    end

    // Next-state logic: grant from idle, release, preempt at the hold limit, or keep holding.
    always_comb begin
        state_n    = state;
        idx_n      = gnt_idx;
        last_idx_n = last_idx;
        hold_cnt_n = hold_cnt;
        case (state)
            IDLE: begin
                if (en && any_req) begin
                    state_n    = GRANT;
                    idx_n      = win_idx;
                    hold_cnt_n = HC_W'(1);
                end
            end
            GRANT: begin
                if (!req[gnt_idx]) begin
                    last_idx_n = gnt_idx;
                    if (en && any_req) begin
                        idx_n      = win_idx;
                        hold_cnt_n = HC_W'(1);
                    end else begin
                        state_n    = IDLE;
                        hold_cnt_n = '0;
                    end
                end else if (hold_cnt == HOLD_MAX && others_req) begin
                    if (en) begin
                        last_idx_n = gnt_idx;
                        idx_n      = win_idx;
                        hold_cnt_n = HC_W'(1);
                    end
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_cnt_n = hold_cnt + HC_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Decode the next owner so the grant can be registered alongside its index.
    onehot_dec2to4 u_dec (
        .idx    (idx_n),
        .en     (state_n == GRANT),
        .onehot (gnt_n)
    );

    // State, rotation pointer, hold counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_idx  <= 2'd3;
            hold_cnt  <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            gnt       <= '0;
        end else begin
            state     <= state_n;
            last_idx  <= last_idx_n;
            hold_cnt  <= hold_cnt_n;
            gnt_idx   <= idx_n;
            gnt_valid <= (state_n == GRANT);
            gnt       <= gnt_n;
        end
    end

endmodule
